cmos_strobe_gen: RTL and testbench

Downstream companion of the CMOS trigger generator in the cmlk timing generator IP. It consumes the periodic trigger pulse, detects each rising edge and, after a programmable delay, drives an illumination strobe of programmable width, both with 1 µs resolution. It also counts accepted triggers and flags triggers that arrive while a strobe sequence is still running.

---
 rtl/cmlk_timing_defs_pkg.sv | 30 +++
 rtl/us_tick_gen.sv | 54 +++++
 rtl/cmos_strobe_gen.sv | 176 +++++++++++++++++
 tb/tb_cmos_strobe_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmlk_timing_defs_pkg.sv
// ----------------------------------------------------------------------------
// cmlk_timing_defs
// Shared definitions for the cmlk timing generator blocks:
//   - default system clock frequency in MHz
//   - strobe sequencer state encoding
//   - clogb2() helper for sizing counters from elaboration-time constants
// ----------------------------------------------------------------------------
package cmlk_timing_defs;

    localparam int DEF_CLK_FREQ_MHZ = 100;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Bits needed to hold 0..value-1; never less than 1 so a counter of
    // this width is always legal.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// ----------------------------------------------------------------------------
// us_tick_gen
// Restartable microsecond prescaler. Counts 0..CLK_FREQ_MHZ-1 and raises
// tick_o for the cycle in which the count sits on its terminal value.
// A clear restarts the count at 0 on the next clock edge.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clr_i   in   restart the prescaler (takes priority over counting)
//   tick_o  out  one-cycle pulse once per microsecond
// ----------------------------------------------------------------------------
module us_tick_gen
    import cmlk_timing_defs::*;
#(
    parameter int CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int                 PRESC_W = clogb2(CLK_FREQ_MHZ);
    localparam logic [PRESC_W-1:0] TERM    = PRESC_W'(CLK_FREQ_MHZ - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    assign tick_o = (presc_q == TERM);

    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (here via the if/else chain); a missing branch would infer a latch.
    always_comb begin
        if (clr_i) begin
            presc_d = '0;
        end else if (tick_o) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/cmos_strobe_gen.sv
// ----------------------------------------------------------------------------
// cmos_strobe_gen
// Turns each rising edge of the trigger pulse into an illumination strobe:
// after strobe_delay_us microseconds the strobe goes high for
// strobe_width_us microseconds. Triggers arriving while a sequence runs are
// rejected and counted as overruns.
//
// Ports
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   trig_in          in   trigger pulse, synchronous to clk
//   enable           in   1 = accept triggers, 0 = ignore and abort
//   strobe_delay_us  in   delay from trigger edge to strobe, in us
//   strobe_width_us  in   strobe high time in us (0 = no strobe)
//   strobe_out       out  registered illumination strobe
//   busy             out  high while a sequence is running
//   trig_cnt         out  accepted-trigger count, wraps
//   overrun          out  one-cycle pulse per trigger rejected while busy
//   overrun_cnt      out  rejected-trigger count, saturates
// ----------------------------------------------------------------------------
module cmos_strobe_gen
    import cmlk_timing_defs::*;
#(
    parameter int CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
    parameter int TRIG_CNT_W   = 32,
    parameter int OVR_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trig_in,
    input  logic                  enable,
    input  logic [15:0]           strobe_delay_us,
    input  logic [15:0]           strobe_width_us,
    output logic                  strobe_out,
    output logic                  busy,
    output logic [TRIG_CNT_W-1:0] trig_cnt,
    output logic                  overrun,
    output logic [OVR_CNT_W-1:0]  overrun_cnt
);

    logic                  trig_d_q;
    logic [1:0]            state_q,    state_d;
    logic [15:0]           cnt_q,      cnt_d;
    logic [15:0]           dly_q,      dly_d;
    logic [15:0]           wid_q,      wid_d;
    logic                  strobe_q,   strobe_d;
    logic                  ovr_q,      ovr_d;
    logic [TRIG_CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic [OVR_CNT_W-1:0]  ovr_cnt_q,  ovr_cnt_d;

    logic        trig_edge;
    logic        accept;
    logic        reject;
    logic        tick;
    logic [15:0] cnt_nxt;

    assign trig_edge = trig_in & ~trig_d_q;
    assign accept    = enable & trig_edge & (state_q == ST_IDLE);
    assign reject    = enable & trig_edge & (state_q != ST_IDLE);
    assign cnt_nxt   = cnt_q + 16'd1;

    // Accepting a trigger restarts the microsecond grid, so the delay is
    // measured from the accepting edge rather than from a free-running phase.
    us_tick_gen #(
        .CLK_FREQ_MHZ (CLK_FREQ_MHZ)
    ) u_us_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .tick_o (tick)
    );

    // Transitions compare the *next* count against the target so the state
    // change lands on the same edge the counter would reach it, giving an
    // exact D*T / W*T cycle spacing. The counter restarts at 0 on entering
    // ACTIVE; the prescaler has just wrapped there, so it needs no clear.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        wid_d      = wid_q;
        strobe_d   = strobe_q;
        ovr_d      = 1'b0;
        trig_cnt_d = trig_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;

        if (!enable) begin
            state_d  = ST_IDLE;
            strobe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dly_d      = strobe_delay_us;
                        wid_d      = strobe_width_us;
                        cnt_d      = '0;
                        trig_cnt_d = trig_cnt_q + TRIG_CNT_W'(1);
                        if (strobe_delay_us != 16'd0) begin
                            state_d = ST_DELAY;
                        end else if (strobe_width_us != 16'd0) begin
                            state_d  = ST_ACTIVE;
                            strobe_d = 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tick) begin
                        if (cnt_nxt == dly_q) begin
                            cnt_d = '0;
                            if (wid_q != 16'd0) begin
                                state_d  = ST_ACTIVE;
                                strobe_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_nxt;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (tick) begin
                        if (cnt_nxt == wid_q) begin
                            state_d  = ST_IDLE;
                            strobe_d = 1'b0;
                        end else begin
                            cnt_d = cnt_nxt;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    strobe_d = 1'b0;
                end
            endcase

            if (reject) begin
                ovr_d = 1'b1;
                if (ovr_cnt_q != '1) begin
                    ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d_q   <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dly_q      <= '0;
            wid_q      <= '0;
            strobe_q   <= 1'b0;
            ovr_q      <= 1'b0;
            trig_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            trig_d_q   <= trig_in;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            wid_q      <= wid_d;
            strobe_q   <= strobe_d;
            ovr_q      <= ovr_d;
            trig_cnt_q <= trig_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign strobe_out  = strobe_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = ovr_q;
    assign trig_cnt    = trig_cnt_q;
    assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_cmos_strobe_gen.sv
// ----------------------------------------------------------------------------
// tb_cmos_strobe_gen
// Directed bench for cmos_strobe_gen at 100 cycles per microsecond.
// A monitor logs the clock index of strobe/busy transitions; each scenario
// compares those indices against the accepting edge of its trigger.
// ----------------------------------------------------------------------------
module tb_cmos_strobe_gen;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig_in = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] strobe_delay_us = '0;
    logic [15:0] strobe_width_us = '0;
    logic        strobe_out;
    logic        busy;
    logic [31:0] trig_cnt;
    logic        overrun;
    logic [15:0] overrun_cnt;

    cmos_strobe_gen #(
        .CLK_FREQ_MHZ (T),
        .TRIG_CNT_W   (32),
        .OVR_CNT_W    (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trig_in         (trig_in),
        .enable          (enable),
        .strobe_delay_us (strobe_delay_us),
        .strobe_width_us (strobe_width_us),
        .strobe_out      (strobe_out),
        .busy            (busy),
        .trig_cnt        (trig_cnt),
        .overrun         (overrun),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Transition log, sampled 1 time unit after each rising edge.
    int   rise_cyc, fall_cyc, brise_cyc, bfall_cyc, ovr_cycles;
    logic s_prev = 1'b0;
    logic b_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (strobe_out === 1'b1 && s_prev === 1'b0) rise_cyc = cyc;
        if (strobe_out === 1'b0 && s_prev === 1'b1) fall_cyc = cyc;
        if (busy === 1'b1 && b_prev === 1'b0) brise_cyc = cyc;
        if (busy === 1'b0 && b_prev === 1'b1) bfall_cyc = cyc;
        if (overrun === 1'b1) ovr_cycles++;
        s_prev = strobe_out;
        b_prev = busy;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_log();
        rise_cyc   = -1;
        fall_cyc   = -1;
        brise_cyc  = -1;
        bfall_cyc  = -1;
        ovr_cycles = 0;
    endtask

    task automatic set_params(input int d, input int w);
        strobe_delay_us = 16'(d);
        strobe_width_us = 16'(w);
    endtask

    // One-cycle trigger pulse; acc is the index of the edge that samples it.
    task automatic fire(output int acc);
        @(posedge clk); #2 trig_in = 1'b1;
        @(posedge clk); #2 trig_in = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;

        clear_log();
        enable = 1'b1;

        // Reset state
        #22;
        check("rst_strobe", strobe_out, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_trig_cnt", trig_cnt, 0);
        check("rst_ovr_cnt", overrun_cnt, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Basic D=3, W=2
        set_params(3, 2);
        clear_log();
        fire(a);
        check("basic_cnt_e1", trig_cnt, 1);
        check("basic_busy_e1", busy, 1);
        check("basic_strobe_e1", strobe_out, 0);
        wait_idle("basic_idle", 1000);
        check("basic_rise", rise_cyc - a, 300);
        check("basic_fall", fall_cyc - a, 500);
        check("basic_brise", brise_cyc - a, 0);
        check("basic_bfall", bfall_cyc - a, 500);

        // D=0, W=5: strobe straight away
        set_params(0, 5);
        clear_log();
        fire(a);
        check("d0_strobe_e1", strobe_out, 1);
        check("d0_cnt", trig_cnt, 2);
        wait_idle("d0_idle", 1000);
        check("d0_rise", rise_cyc - a, 0);
        check("d0_fall", fall_cyc - a, 500);

        // D=4, W=0: busy only, no strobe
        set_params(4, 0);
        clear_log();
        fire(a);
        check("w0_cnt", trig_cnt, 3);
        wait_idle("w0_idle", 1000);
        check("w0_no_rise", rise_cyc, -1);
        check("w0_brise", brise_cyc - a, 0);
        check("w0_bfall", bfall_cyc - a, 400);

        // D=0, W=0: counted, never busy
        set_params(0, 0);
        clear_log();
        fire(a);
        check("dw0_busy", busy, 0);
        check("dw0_cnt", trig_cnt, 4);
        repeat (5) @(posedge clk);
        #2 check("dw0_no_brise", brise_cyc, -1);

        // Overrun: second edge 500 cycles after the first
        set_params(10, 10);
        clear_log();
        fire(a);
        repeat (498) @(posedge clk);
        fire(b);
        check("ovr_pulse", overrun, 1);
        check("ovr_cnt", overrun_cnt, 1);
        check("ovr_trig_cnt", trig_cnt, 5);
        check("ovr_still_busy", busy, 1);
        @(posedge clk); #2;
        check("ovr_pulse_end", overrun, 0);
        wait_idle("ovr_idle", 3000);
        check("ovr_rise", rise_cyc - a, 1000);
        check("ovr_fall", fall_cyc - a, 2000);
        check("ovr_one_cycle", ovr_cycles, 1);

        // Edge on the ACTIVE->IDLE edge is an overrun
        set_params(0, 1);
        clear_log();
        fire(a);
        repeat (98) @(posedge clk);
        fire(b);
        check("rt0_overrun", overrun, 1);
        check("rt0_ovr_cnt", overrun_cnt, 2);
        check("rt0_trig_cnt", trig_cnt, 6);
        check("rt0_busy", busy, 0);
        check("rt0_fall", fall_cyc - a, 100);
        repeat (3) @(posedge clk);

        // Edge one cycle later is accepted
        clear_log();
        fire(a);
        repeat (99) @(posedge clk);
        fire(b);
        check("rt1_trig_cnt", trig_cnt, 8);
        check("rt1_ovr_cnt", overrun_cnt, 2);
        check("rt1_busy", busy, 1);
        check("rt1_strobe", strobe_out, 1);
        wait_idle("rt1_idle", 1000);

        // Delay changed mid-DELAY applies to the next trigger only
        set_params(3, 2);
        clear_log();
        fire(a);
        repeat (50) @(posedge clk);
        #2 strobe_delay_us = 16'd7;
        wait_idle("prm1_idle", 1000);
        check("prm1_rise", rise_cyc - a, 300);
        check("prm1_fall", fall_cyc - a, 500);
        clear_log();
        fire(a);
        wait_idle("prm2_idle", 1500);
        check("prm2_rise", rise_cyc - a, 700);
        check("prm2_fall", fall_cyc - a, 900);
        check("prm_trig_cnt", trig_cnt, 10);

        // Enable drop mid-ACTIVE
        set_params(0, 10);
        clear_log();
        fire(a);
        repeat (200) @(posedge clk);
        #2 enable = 1'b0;
        #1 check("en_strobe_pre", strobe_out, 1);
        @(posedge clk); #2;
        check("en_strobe_low", strobe_out, 0);
        check("en_busy_low", busy, 0);
        check("en_fall", fall_cyc - a, 201);
        fire(b);
        check("en_off_overrun", overrun, 0);
        repeat (4) @(posedge clk);
        fire(b);
        check("en_off_trig_cnt", trig_cnt, 11);
        check("en_off_ovr_cnt", overrun_cnt, 2);
        check("en_off_busy", busy, 0);
        check("en_off_ovr_cycles", ovr_cycles, 0);
        enable = 1'b1;
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-ACTIVE
        set_params(0, 5);
        clear_log();
        fire(a);
        repeat (100) @(posedge clk);
        #3;
        check("arst_pre_strobe", strobe_out, 1);
        rst_n = 1'b0;
        #1;
        check("arst_strobe", strobe_out, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_trig_cnt", trig_cnt, 0);
        check("arst_ovr_cnt", overrun_cnt, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        set_params(1, 1);
        clear_log();
        fire(a);
        check("post_rst_cnt", trig_cnt, 1);
        wait_idle("post_rst_idle", 1000);
        check("post_rst_rise", rise_cyc - a, 100);
        check("post_rst_fall", fall_cyc - a, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
